fetch_stage: RTL and testbench

//   IF stage plus IF/ID pipeline register for the 5-stage RV32I pipeline.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/fetch_skid_buf.sv | 38 +++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, bubble encoding, base opcodes
// used by decode, and the fetch FSM state encoding.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // S_REQ: fetching at PCF; S_HOLD: fetched word parked in skid while decode
    // stalls; S_DRAIN: waiting out a request abandoned by a redirect.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction fetched while decode was stalled.
module fetch_skid_buf
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic            unload,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic            valid
);

    // Occupancy flag: clear (redirect) wins over load, load over unload.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

    // Payload is only meaningful while valid, so it is captured without reset.
    always_ff @(posedge clk) begin
        if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: PCF, IMEM ready handshake, redirect
// drain handling, a one-entry skid for decode stalls, and the IF/ID register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int               XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_en,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            InstrValidD,
    output logic            FetchBusyF
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pcf, pcf_n;
    logic [XLEN-1:0] redir_pc, redir_pc_n;

    logic            transfer;
    logic            load_fetch;
    logic            load_skid;
    logic            skid_load;
    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;

    // A drain keeps requesting regardless of req_en so the abandoned access completes.
    assign imem_req   = (req_en & (state != S_HOLD)) | (state == S_DRAIN);
    // In S_DRAIN PCF still holds the abandoned address; the target waits in redir_pc.
    assign imem_addr  = pcf;
    assign transfer   = imem_req & imem_ready;
    // Redirect discards any same-cycle rdata and any parked skid entry.
    assign load_fetch = (state == S_REQ) & transfer & ~PCSrcE;
    assign skid_load  = load_fetch & StallD;
    assign load_skid  = (state == S_HOLD) & skid_valid & ~StallD & ~PCSrcE;
    assign FetchBusyF = PCSrcE | ~(load_fetch | ((state == S_HOLD) & skid_valid));

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .clear    (PCSrcE),
        .unload   (load_skid),
        .instr_in (imem_rdata),
        .pc_in    (pcf),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .valid    (skid_valid)
    );

    // Next-state, next-PC and drain target; redirect takes priority over everything.
    always_comb begin
        state_n    = state;
        pcf_n      = pcf;
        redir_pc_n = redir_pc;
        if (PCSrcE) begin
            if (imem_req && !imem_ready) begin
                redir_pc_n = PCTargetE;
                state_n    = S_DRAIN;
            end else begin
                pcf_n   = PCTargetE;
                state_n = S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (transfer) begin
                        pcf_n = pcf + PC_STEP;
                        if (StallD) state_n = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!StallD) state_n = S_REQ;
                end
                S_DRAIN: begin
                    if (transfer) begin
                        pcf_n   = redir_pc;
                        state_n = S_REQ;
                    end
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    // FSM state, PCF and drain target registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            pcf      <= RESET_PC;
            redir_pc <= RESET_PC;
        end else begin
            state    <= state_n;
            pcf      <= pcf_n;
            redir_pc <= redir_pc_n;
        end
    end

    // IF/ID register: flush beats stall, stall beats any load; otherwise a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD      <= NOP_INSTR;
            PCD         <= '0;
            PCPlus4D    <= '0;
            InstrValidD <= 1'b0;
        end else if (FlushD) begin
            InstrD      <= NOP_INSTR;
            InstrValidD <= 1'b0;
        end else if (!StallD) begin
            if (load_fetch) begin
                InstrD      <= imem_rdata;
                PCD         <= pcf;
                PCPlus4D    <= pcf + PC_STEP;
                InstrValidD <= 1'b1;
            end else if (load_skid) begin
                InstrD      <= skid_instr;
                PCD         <= skid_pc;
                PCPlus4D    <= skid_pc + PC_STEP;
                InstrValidD <= 1'b1;
            end else begin
                InstrD      <= NOP_INSTR;
                InstrValidD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: stimulus pushes expected PCs,
// a negedge monitor pops and compares every newly presented instruction.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, req_en, StallD, FlushD, PCSrcE, imem_ready;
    logic [31:0] PCTargetE, imem_rdata, imem_addr;
    logic        imem_req, InstrValidD, FetchBusyF;
    logic [31:0] InstrD, PCD, PCPlus4D;

    logic        reset_b, imem_req_b, InstrValidD_b, FetchBusyF_b;
    logic [31:0] imem_addr_b, imem_rdata_b, InstrD_b, PCD_b, PCPlus4D_b;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic        held = 1'b1;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata   = instr_of(imem_addr);
    assign imem_rdata_b = instr_of(imem_addr_b);

    fetch_stage dut (
        .clk(clk), .reset(reset), .req_en(req_en), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .InstrValidD(InstrValidD), .FetchBusyF(FetchBusyF)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset_b), .req_en(1'b1), .StallD(1'b0), .FlushD(1'b0),
        .PCSrcE(1'b0), .PCTargetE(32'h0), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_ready(1'b1), .imem_rdata(imem_rdata_b), .InstrD(InstrD_b), .PCD(PCD_b),
        .PCPlus4D(PCPlus4D_b), .InstrValidD(InstrValidD_b), .FetchBusyF(FetchBusyF_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue n back-to-back ready fetches starting at pc, expecting each in order.
    task automatic fetch_seq(input logic [31:0] pc, input int n);
        imem_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pc + 32'(4 * i));
            @(negedge clk);
            chk("fetch_addr", imem_addr, pc + 32'(4 * i));
            chk("fetch_req", {31'b0, imem_req}, 32'd1);
            tick();
        end
    endtask

    // IF/ID keeps its old content after an edge where StallD (without FlushD) or reset applied.
    always @(posedge clk) held <= reset | (StallD & ~FlushD);

    // Monitor: every newly loaded valid instruction must match the head of the queue.
    always @(negedge clk) begin
        if (InstrValidD && !held) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_instr: actual pc=%h expected none", PCD);
            end else begin
                automatic logic [31:0] pc = exp_q.pop_front();
                chk("mon_pcd", PCD, pc);
                chk("mon_instr", InstrD, instr_of(pc));
                chk("mon_pcplus4", PCPlus4D, pc + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; reset_b = 1'b1; req_en = 1'b1; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'h0; imem_ready = 1'b1;  // ready during reset is ignored
        tick();
        chk("rst_instr", InstrD, NOP);
        chk("rst_valid", {31'b0, InstrValidD}, 32'd0);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pcplus4", PCPlus4D, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        tick();
        reset = 1'b0;

        // Ready every cycle: 0,4,8,C back to back.
        fetch_seq(32'h0, 4);

        // Three wait cycles at 0x10.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_addr", imem_addr, 32'h10);
            chk("wait_busy", {31'b0, FetchBusyF}, 32'd1);
            if (i > 0) chk("wait_bubble", {31'b0, InstrValidD}, 32'd0);
            tick();
        end
        chk("wait_bubble3", {31'b0, InstrValidD}, 32'd0);
        chk("bubble_nop", InstrD, NOP);
        fetch_seq(32'h10, 4);

        // Decode stall while 0x20 arrives.
        StallD = 1'b1;
        imem_ready = 1'b1;
        exp_q.push_back(32'h20);
        @(negedge clk);
        chk("stall_addr", imem_addr, 32'h20);
        tick();
        @(negedge clk);
        chk("hold_noreq", {31'b0, imem_req}, 32'd0);
        tick();
        StallD = 1'b0;
        @(negedge clk);
        chk("release_noreq", {31'b0, imem_req}, 32'd0);
        tick();
        fetch_seq(32'h24, 7);

        // Redirect to 0x100 while 0x40 is outstanding.
        imem_ready = 1'b0;
        @(negedge clk);
        chk("pend_addr", imem_addr, 32'h40);
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        tick();
        PCSrcE = 1'b0; req_en = 1'b0;
        @(negedge clk);
        chk("drain_req", {31'b0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h40);
        tick();
        req_en = 1'b1; imem_ready = 1'b1;
        @(negedge clk);
        chk("drain_done_addr", imem_addr, 32'h40);
        tick();
        fetch_seq(32'h100, 2);

        // FlushD with StallD, then redirect out of S_HOLD.
        StallD = 1'b1; FlushD = 1'b1;
        tick();
        FlushD = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h200;
        @(negedge clk);
        chk("flush_instr", InstrD, NOP);
        chk("flush_valid", {31'b0, InstrValidD}, 32'd0);
        chk("hold_redir_noreq", {31'b0, imem_req}, 32'd0);
        tick();
        PCSrcE = 1'b0; StallD = 1'b0;
        fetch_seq(32'h200, 1);

        // Reset while draining.
        imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h300;
        tick();
        PCSrcE = 1'b0;
        @(negedge clk);
        chk("drain2_addr", imem_addr, 32'h204);
        tick();
        reset = 1'b1; imem_ready = 1'b1;
        tick();
        reset = 1'b0;
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_valid", {31'b0, InstrValidD}, 32'd0);
        fetch_seq(32'h0, 2);
        imem_ready = 1'b0;
        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // Wrap-around instance with RESET_PC = FFFFFFFC.
        chk("wrap_rst_addr", imem_addr_b, 32'hFFFF_FFFC);
        reset_b = 1'b0;
        @(negedge clk);
        chk("wrap_first_addr", imem_addr_b, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        chk("wrap_second_addr", imem_addr_b, 32'h0);
        chk("wrap_pcd", PCD_b, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", PCPlus4D_b, 32'h0);
        chk("wrap_instr", InstrD_b, instr_of(32'hFFFF_FFFC));
        chk("wrap_valid", {31'b0, InstrValidD_b}, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
